// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO; rev 1.0
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide-by-zero finishes in one cycle.
`default_nettype none

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [5:0]       ALU_Op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam int         CW       = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
`ifdef MULDIV_DIVZERO_FAST_EN
  logic               dz_skip;
`endif

  logic               is_md;
  logic               is_hilo;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign is_md     = ALU_Op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_hilo   = ALU_Op inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO};
  assign signed_op = is_md & ~ALU_Op[0];
  assign a_neg     = signed_op & rs_val[WIDTH-1];
  assign b_neg     = signed_op & rt_val[WIDTH-1];
  assign a_mag     = a_neg ? -rs_val : rs_val;
  assign b_mag     = b_neg ? -rt_val : rt_val;
  assign accept    = valid_in & is_md & ~busy;
  assign stall     = valid_in & busy & (is_md | is_hilo);

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  // A clear borrow bit means the shifted remainder is at least the divisor.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
  assign prod_fix  = neg_q ? -acc : acc;
  assign q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    result = '0;
    if (ALU_Op == OP_MFHI)      result = hi;
    else if (ALU_Op == OP_MFLO) result = lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
      dz_skip  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
      div_zero <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy   <= 1'b1;
            acc    <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            cnt    <= CW'(WIDTH - 1);
            is_div <= ALU_Op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            state  <= ALU_Op[1] ? S_DIV : S_MUL;
`ifdef MULDIV_DIVZERO_FAST_EN
            dz_skip <= ALU_Op[1] && (rt_val == '0);
            if (ALU_Op[1] && (rt_val == '0)) state <= S_FIX;
`endif
          end else if (valid_in && ALU_Op == OP_MTHI) begin
            hi <= rs_val;
          end else if (valid_in && ALU_Op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_DIV: begin
          if (!div_trial[WIDTH]) acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                   acc <= {acc[2*WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
`ifdef MULDIV_DIVZERO_FAST_EN
          if (dz_skip) begin
            div_zero <= 1'b1;
          end else
`endif
          if (is_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef MULDIV_DIVZERO_FAST_EN
  assign div_zero = 1'b0;
`endif

endmodule

`default_nettype wire
